ir_encoder: RTL and testbench
=============================

IR_ENCODER -- requirements
Module: ir_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset is synchronous and active-low.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 bit each: field-level instruction handshake; transfer occurs on an edge where both are high.
REQ-004 SHALL have opcode [2:0], alu_op [1:0], fmt [1:0], rn [2:0], rd [2:0], rm [2:0], shift_op [1:0], cond [2:0], all inputs: instruction fields, sampled on transfer.
REQ-005 SHALL have imm, input, 16 bits: signed immediate, sampled on transfer.
REQ-006 SHALL have load_addr (input, 1) and start_addr (input, 8): load the write-address counter.
REQ-007 SHALL have mem_wr (output, 1), mem_addr (output, 8), mem_wdata (output, 16) and mem_ack (input, 1): instruction-memory write handshake.
REQ-008 SHALL have err (output, 1) and err_clr (input, 1): sticky immediate-range error flag and its clear.
REQ-009 SHALL have wrap (output, 1): sticky flag, set when mem_addr wraps from 255 to 0.

Function
REQ-010 Encoding SHALL be: ir[15:13]=opcode, ir[12:11]=alu_op, then by fmt:
 - FMT_REG (00): ir[10:8]=rn, ir[7:5]=rd, ir[4:3]=shift_op, ir[2:0]=rm.
 - FMT_IMM8 (01): ir[10:8]=rn, ir[7:0]=imm[7:0].
 - FMT_IMM5 (10): ir[10:8]=rn, ir[7:5]=rd, ir[4:0]=imm[4:0].
 - FMT_BR (11): ir[10:8]=cond, ir[7:0]=imm[7:0].
REQ-011 Range check: FMT_IMM8/FMT_BR require imm in -128..127; FMT_IMM5 requires -16..15; FMT_REG ignores imm.
REQ-012 An out-of-range transfer SHALL be consumed (handshake completes), SHALL NOT be enqueued, and SHALL set err from the next edge.
REQ-013 Encoded words SHALL enter a 4-entry FIFO; in_ready = (FIFO occupancy < 4), derived from registered occupancy only (no same-cycle pop bypass).
REQ-014 Write FSM states IDLE and WRITE; in IDLE with FIFO non-empty: register mem_wr=1, mem_addr=counter, mem_wdata=head; go to WRITE.
REQ-015 In WRITE, outputs SHALL hold stable until mem_ack=1; on ack: pop, counter+1 (mod 256); if occupancy after pop >0, present next head in WRITE with no idle cycle, else mem_wr=0 and go to IDLE.
REQ-016 mem_ack while in IDLE SHALL be ignored.
REQ-017 Latency: a word accepted on edge E SHALL, with FIFO empty and FSM in IDLE, appear on mem_wr/mem_wdata registered at edge E+1.
REQ-018 Push and pop on the same edge SHALL leave occupancy unchanged and preserve order.
REQ-019 load_addr SHALL be honoured only in IDLE with FIFO empty (counter=start_addr next edge); otherwise ignored.
REQ-020 Counter increment from 255 SHALL give 0 and set wrap.
REQ-021 err_clr SHALL clear err; simultaneous new range error SHALL win (err stays 1).

Reset
REQ-022 On rst_n=0 at an edge: FIFO empty, FSM=IDLE, counter=0, mem_wr=0, mem_addr=0, mem_wdata=0, err=0, wrap=0; in_ready=1 from first cycle after reset.
REQ-023 Reset mid-WRITE SHALL abandon the pending word and all queued words.

Structure
REQ-024 Shared package risc_pkg SHALL hold the fmt enum, FSM state enum, field bit-position constants and FIFO depth constant.
REQ-025 The FIFO SHALL be a sub-module ir_fifo (parameterised width/depth); encode, range check, FSM and counter stay in ir_encoder.

Verification
REQ-026 FMT_REG opcode=101 alu_op=00 rn=1 rd=2 shift_op=01 rm=0, mem_ack tied 1 -> mem_wdata=0xA148 at mem_addr=0x00.
REQ-027 FMT_IMM8 opcode=110 alu_op=10 rn=3 imm=-1 -> 0xD3FF; FMT_BR opcode=001 cond=010 imm=5 -> 0x2205; FMT_IMM5 opcode=011 rn=2 rd=4 imm=-3 -> 0x629D; written to consecutive addresses.
REQ-028 FMT_IMM8 imm=200 -> handshake completes, err=1, no mem_wr; err_clr -> err=0.
REQ-029 mem_ack held 0, push 5 words -> in_ready=0 after 4th; release ack -> 4 words written in order, back-to-back, then 5th accepted.
REQ-030 load_addr with start_addr=0xFE, push 3 words -> addresses 0xFE, 0xFF, 0x00, wrap=1.
REQ-031 rst_n=0 during WRITE with 3 queued -> all outputs at reset values next cycle, no further writes.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: instruction formats, write-FSM states, IR field positions, FIFO depth and encode/range helpers
package risc_pkg;
  typedef enum logic [1:0] {FMT_REG = 2'b00, FMT_IMM8 = 2'b01, FMT_IMM5 = 2'b10, FMT_BR = 2'b11} fmt_e;
  typedef enum logic {S_IDLE, S_WRITE} state_e;
  localparam int IR_W = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int OP_LSB = 13;
  localparam int ALU_LSB = 11;
  localparam int RN_LSB = 8;
  localparam int RD_LSB = 5;
  localparam int SH_LSB = 3;
  function automatic logic [IR_W-1:0] encode(fmt_e f, logic [2:0] op, logic [1:0] alu, logic [2:0] rn,
                                             logic [2:0] rd, logic [2:0] rm, logic [1:0] sh,
                                             logic [2:0] cnd, logic [15:0] imm);
    logic [IR_W-1:0] ir;
    ir = '0;
    ir[OP_LSB +: 3] = op;
    ir[ALU_LSB +: 2] = alu;
    ir[RN_LSB +: 3] = (f == FMT_BR) ? cnd : rn;
    ir[7:0] = (f == FMT_REG) ? {rd, sh, rm} : (f == FMT_IMM5) ? {rd, imm[4:0]} : imm[7:0];
    return ir;
  endfunction
  // In range when every bit above the field's sign bit matches it
  function automatic logic imm_ok(fmt_e f, logic [15:0] imm);
    return (f == FMT_REG) ? 1'b1 :
           (f == FMT_IMM5) ? (&imm[15:4] || ~|imm[15:4]) : (&imm[15:7] || ~|imm[15:7]);
  endfunction
endpackage

// File: rtl/ir_fifo.sv
// ir_fifo: circular FIFO exposing head and the entry that becomes head after a pop
module ir_fifo #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [W-1:0]       wdata,
  output logic [W-1:0]       rdata,
  output logic [W-1:0]       next_rdata,
  output logic [$clog2(D):0] count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  // With a single entry left, the word arriving this cycle becomes the next head
  assign next_rdata = (count > (AW+1)'(1)) ? mem[rd_ptr + 1'b1] : wdata;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/ir_encoder.sv
// ir_encoder: encodes instruction fields, range-checks immediates, queues words and writes them to instruction memory
module ir_encoder
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  opcode,
  input  logic [1:0]  alu_op,
  input  logic [1:0]  fmt,
  input  logic [2:0]  rn,
  input  logic [2:0]  rd,
  input  logic [2:0]  rm,
  input  logic [1:0]  shift_op,
  input  logic [2:0]  cond,
  input  logic [15:0] imm,
  input  logic        load_addr,
  input  logic [7:0]  start_addr,
  output logic        mem_wr,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        err,
  input  logic        err_clr,
  output logic        wrap
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state, state_nx;
  logic [CW-1:0] count;
  logic [IR_W-1:0] ir, head, next_head, wdata_nx;
  logic [7:0] cnt, cnt_nx, addr_nx;
  logic fire, ok, push, pop, next_avail, wr_nx, wrap_nx;
  assign in_ready = count < CW'(FIFO_DEPTH);
  assign fire = in_valid && in_ready;
  assign ok = imm_ok(fmt_e'(fmt), imm);
  assign push = fire && ok;
  assign ir = encode(fmt_e'(fmt), opcode, alu_op, rn, rd, rm, shift_op, cond, imm);
  assign next_avail = (count > CW'(1)) || push;
  ir_fifo #(.W(IR_W), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .wdata(ir),
    .rdata(head), .next_rdata(next_head), .count(count)
  );
  always_comb begin
    state_nx = state;
    wr_nx = mem_wr;
    addr_nx = mem_addr;
    wdata_nx = mem_wdata;
    cnt_nx = cnt;
    wrap_nx = wrap;
    pop = 1'b0;
    if (state == S_IDLE) begin
      if (count != '0) begin
        state_nx = S_WRITE;
        wr_nx = 1'b1;
        addr_nx = cnt;
        wdata_nx = head;
      end else if (load_addr) begin
        cnt_nx = start_addr;
      end
    end else if (mem_ack) begin
      pop = 1'b1;
      cnt_nx = cnt + 8'd1;
      wrap_nx = wrap || (cnt == 8'hff);
      addr_nx = cnt + 8'd1;
      wdata_nx = next_head;
      state_nx = next_avail ? S_WRITE : S_IDLE;
      wr_nx = next_avail;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      err <= 1'b0;
      wrap <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      mem_wr <= wr_nx;
      mem_addr <= addr_nx;
      mem_wdata <= wdata_nx;
      err <= (fire && !ok) || (err && !err_clr);
      wrap <= wrap_nx;
    end
  end
endmodule

// File: tb/tb_ir_encoder.sv
// tb_ir_encoder: directed scenario tasks for ir_encoder with hand-computed expected words
module tb_ir_encoder;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready;
  logic [2:0] opcode = '0, rn = '0, rd = '0, rm = '0, cond = '0;
  logic [1:0] alu_op = '0, fmt = '0, shift_op = '0;
  logic [15:0] imm = '0, mem_wdata;
  logic load_addr = 1'b0, mem_wr, mem_ack = 1'b0, err, err_clr = 1'b0, wrap;
  logic [7:0] start_addr = '0, mem_addr;
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [7:0] wa[$];
  logic [15:0] wd[$];
  int wc[$];

  ir_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .alu_op(alu_op), .fmt(fmt), .rn(rn), .rd(rd), .rm(rm), .shift_op(shift_op), .cond(cond),
    .imm(imm), .load_addr(load_addr), .start_addr(start_addr), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .err(err),
    .err_clr(err_clr), .wrap(wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Inputs change 1 time unit after the rising edge, so negedge values are what the next edge sees
  always @(negedge clk) begin
    if (rst_n && mem_wr && mem_ack) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
  end

  task automatic clr_log();
    wa.delete();
    wd.delete();
    wc.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] f, input logic [2:0] op, input logic [1:0] alu,
                      input logic [2:0] rn_v, input logic [2:0] rd_v, input logic [2:0] rm_v,
                      input logic [1:0] sh, input logic [2:0] cnd, input logic [15:0] im);
    int n = 0;
    fmt = f; opcode = op; alu_op = alu; rn = rn_v; rd = rd_v; rm = rm_v;
    shift_op = sh; cond = cnd; imm = im; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick(1);
      n++;
    end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL send_timeout: in_ready got %b after %0d cycles, required 1", in_ready, n); end
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b required 0", mem_wr); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %h required 00", mem_addr); end
    n_checks++; if (mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_wdata: got %h required 0000", mem_wdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b required 0", wrap); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_reg_latency();
    clr_log();
    mem_ack = 1'b1;
    send(2'b00, 3'b101, 2'b00, 3'd1, 3'd2, 3'd0, 2'b01, 3'd0, 16'h0000);
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reg_early_wr: got %b required 0", mem_wr); end
    tick(1);
    n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL reg_wr: got %b required 1", mem_wr); end
    n_checks++; if (mem_wdata !== 16'hA148) begin n_fail++; $display("FAIL reg_wdata: got %h required a148", mem_wdata); end
    n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reg_addr: got %h required 00", mem_addr); end
    tick(1);
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reg_wr_drop: got %b required 0", mem_wr); end
  endtask

  task automatic test_formats();
    logic [15:0] ed [3] = '{16'hD3FF, 16'h2205, 16'h629D};
    clr_log();
    send(2'b01, 3'b110, 2'b10, 3'd3, 3'd0, 3'd0, 2'b00, 3'd0, 16'hFFFF);
    send(2'b11, 3'b001, 2'b00, 3'd7, 3'd0, 3'd0, 2'b00, 3'b010, 16'h0005);
    send(2'b10, 3'b011, 2'b00, 3'd2, 3'd4, 3'd0, 2'b00, 3'd0, 16'hFFFD);
    tick(8);
    n_checks++; if (wd.size() != 3) begin n_fail++; $display("FAIL fmt_count: got %0d writes required 3", wd.size()); end
    for (int i = 0; i < 3 && i < wd.size(); i++) begin
      n_checks++; if (wd[i] !== ed[i]) begin n_fail++; $display("FAIL fmt_data[%0d]: got %h required %h", i, wd[i], ed[i]); end
      n_checks++; if (wa[i] !== 8'(i + 1)) begin n_fail++; $display("FAIL fmt_addr[%0d]: got %h required %h", i, wa[i], 8'(i + 1)); end
    end
  endtask

  task automatic test_range();
    clr_log();
    send(2'b01, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'd200);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err_set: got %b required 1", err); end
    tick(3);
    n_checks++; if (wd.size() != 0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL range_no_write: got %0d writes mem_wr %b required 0 and 0", wd.size(), mem_wr); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err_sticky: got %b required 1", err); end
    err_clr = 1'b1;
    tick(1);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL range_err_clr: got %b required 0", err); end
    send(2'b10, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'd16);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_err_wins: got %b required 1", err); end
    tick(1);
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL range_err_clr2: got %b required 0", err); end
    send(2'b10, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'hFFF0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL range_imm5_min_ok: got %b required 0", err); end
    send(2'b11, 3'b000, 2'b00, 3'd0, 3'd0, 3'd0, 2'b00, 3'd0, 16'hFF7F);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL range_br_low: got %b required 1", err); end
    tick(5);
    n_checks++; if (wd.size() != 1) begin n_fail++; $display("FAIL range_count: got %0d writes required 1", wd.size()); end
    else begin
      n_checks++; if (wd[0] !== 16'h0010 || wa[0] !== 8'h04) begin n_fail++; $display("FAIL range_boundary_word: got %h@%h required 0010@04", wd[0], wa[0]); end
    end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    clr_log();
    mem_ack = 1'b0;
    for (int k = 1; k <= 4; k++) send(2'b01, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 16'(k));
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: in_ready got %b required 0", in_ready); end
    fork
      send(2'b01, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 16'd5);
      begin
        tick(3);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_still_full: in_ready got %b required 0", in_ready); end
        n_checks++; if (mem_wr !== 1'b1 || mem_wdata !== 16'h0001 || mem_addr !== 8'h05) begin n_fail++; $display("FAIL b2b_hold: got wr %b %h@%h required 1 0001@05", mem_wr, mem_wdata, mem_addr); end
        mem_ack = 1'b1;
      end
    join
    tick(10);
    n_checks++; if (wd.size() != 5) begin n_fail++; $display("FAIL b2b_count: got %0d writes required 5", wd.size()); end
    for (int i = 0; i < 5 && i < wd.size(); i++) begin
      n_checks++; if (wd[i] !== 16'(i + 1) || wa[i] !== 8'(i + 5)) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h@%h required %h@%h", i, wd[i], wa[i], 16'(i + 1), 8'(i + 5)); end
    end
    for (int i = 1; i < 4 && i < wc.size(); i++) begin
      n_checks++; if (wc[i] !== wc[i-1] + 1) begin n_fail++; $display("FAIL b2b_gap[%0d]: got cycle %0d required %0d", i, wc[i], wc[i-1] + 1); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ea [3] = '{8'hFE, 8'hFF, 8'h00};
    clr_log();
    load_addr = 1'b1;
    start_addr = 8'hFE;
    tick(1);
    load_addr = 1'b0;
    n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_early: got %b required 0", wrap); end
    for (int k = 1; k <= 3; k++) send(2'b01, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 16'(k * 17));
    tick(6);
    n_checks++; if (wa.size() != 3) begin n_fail++; $display("FAIL wrap_count: got %0d writes required 3", wa.size()); end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      n_checks++; if (wa[i] !== ea[i]) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, wa[i], ea[i]); end
    end
    n_checks++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_flag: got %b required 1", wrap); end
  endtask

  task automatic test_reset_mid_write();
    clr_log();
    mem_ack = 1'b0;
    for (int k = 1; k <= 3; k++) send(2'b01, 3'd7, 2'd3, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 16'(k));
    send(2'b01, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 2'd0, 3'd0, 16'd300);
    n_checks++; if (mem_wr !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got wr %b err %b required 1 1", mem_wr, err); end
    rst_n = 1'b0;
    tick(1);
    n_checks++; if (mem_wr !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_outputs: got %b %h %h required 0 00 0000", mem_wr, mem_addr, mem_wdata); end
    n_checks++; if (err !== 1'b0 || wrap !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags: got err %b wrap %b rdy %b required 0 0 1", err, wrap, in_ready); end
    rst_n = 1'b1;
    mem_ack = 1'b1;
    tick(6);
    n_checks++; if (wd.size() != 0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_abandon: got %0d writes wr %b required 0 0", wd.size(), mem_wr); end
  endtask

  initial begin
    test_reset();
    test_reg_latency();
    test_formats();
    test_range();
    test_back_to_back();
    test_wrap();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end
endmodule
